axi_lite_cmd_master: RTL

AXI4-Lite master that converts single-word register commands from local control logic into AXI4-Lite write or read transactions, one outstanding transaction at a time. It is the initiator counterpart of the dummy RAM-backed AXI slave and drives the same 16-bit-address, 32-bit-data s_axi bus. It sits between a sequencer or bring-up controller and the Time Card AXI interconnect, and reports the response code, read data and timeout status back to the requester.

---
 rtl/axi_lite_cmd_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns single-word register commands into AXI4-Lite transactions, one at a time.
// Optional transaction timeout enabled by defining AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master #(
    parameter int ClockPeriod_Gen = 20,
    parameter int TimeoutNs_Gen   = 10000
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRstN_RstIn,
    input  logic        CmdValid_ValIn,
    output logic        CmdReady_RdyOut,
    input  logic        CmdWrite_EnIn,
    input  logic [15:0] CmdAddress_AdrIn,
    input  logic [31:0] CmdData_DatIn,
    input  logic [3:0]  CmdStrobe_DatIn,
    output logic        RespValid_ValOut,
    input  logic        RespReady_RdyIn,
    output logic [31:0] RespData_DatOut,
    output logic [1:0]  RespResponse_DatOut,
    output logic        RespTimeout_ValOut,
    output logic        AxiWriteAddrValid_ValOut,
    input  logic        AxiWriteAddrReady_RdyIn,
    output logic [15:0] AxiWriteAddrAddress_AdrOut,
    output logic [2:0]  AxiWriteAddrProt_DatOut,
    output logic        AxiWriteDataValid_ValOut,
    input  logic        AxiWriteDataReady_RdyIn,
    output logic [31:0] AxiWriteDataData_DatOut,
    output logic [3:0]  AxiWriteDataStrobe_DatOut,
    input  logic        AxiWriteRespValid_ValIn,
    output logic        AxiWriteRespReady_RdyOut,
    input  logic [1:0]  AxiWriteRespResponse_DatIn,
    output logic        AxiReadAddrValid_ValOut,
    input  logic        AxiReadAddrReady_RdyIn,
    output logic [15:0] AxiReadAddrAddress_AdrOut,
    output logic [2:0]  AxiReadAddrProt_DatOut,
    input  logic        AxiReadDataValid_ValIn,
    output logic        AxiReadDataReady_RdyOut,
    input  logic [1:0]  AxiReadDataResponse_DatIn,
    input  logic [31:0] AxiReadDataData_DatIn
);
    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    localparam int TIMEOUT_CYCLES = TimeoutNs_Gen / ClockPeriod_Gen;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("timeout must be at least one clock period");
    end

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic        aw_q, aw_d;
    logic        w_q, w_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic        active;
`endif

    always_ff @(posedge SysClk_ClkIn) begin
        if (!SysRstN_RstIn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            aw_q    <= 1'b0;
            w_q     <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            aw_q    <= aw_d;
            w_q     <= w_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        aw_d    = aw_q;
        w_d     = w_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: if (CmdValid_ValIn) begin
                addr_d  = CmdAddress_AdrIn;
                wdata_d = CmdData_DatIn;
                strb_d  = CmdStrobe_DatIn;
                aw_d    = CmdWrite_EnIn;
                w_d     = CmdWrite_EnIn;
                state_d = CmdWrite_EnIn ? WR_ADDR_DATA : RD_ADDR;
            end
            // AW and W retire independently; leave only when both have handshaked
            WR_ADDR_DATA: begin
                aw_d    = aw_q & ~AxiWriteAddrReady_RdyIn;
                w_d     = w_q & ~AxiWriteDataReady_RdyIn;
                state_d = (!aw_d && !w_d) ? WR_RESP : WR_ADDR_DATA;
            end
            WR_RESP: if (AxiWriteRespValid_ValIn) begin
                rdata_d = '0;
                resp_d  = AxiWriteRespResponse_DatIn;
                state_d = RESP;
            end
            RD_ADDR: state_d = AxiReadAddrReady_RdyIn ? RD_DATA : RD_ADDR;
            RD_DATA: if (AxiReadDataValid_ValIn) begin
                rdata_d = AxiReadDataData_DatIn;
                resp_d  = AxiReadDataResponse_DatIn;
                state_d = RESP;
            end
            RESP:    state_d = RespReady_RdyIn ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
        active = state_q inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
        cnt_d  = active ? cnt_q + 32'd1 : '0;
        tmo_d  = active ? 1'b0 : tmo_q;
        // Abort wins over a same-cycle slave response so the outcome is deterministic
        if (active && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d = RESP;
            aw_d    = 1'b0;
            w_d     = 1'b0;
            rdata_d = '0;
            resp_d  = 2'b10;
            tmo_d   = 1'b1;
        end
`endif
    end

    assign CmdReady_RdyOut            = state_q == IDLE;
    assign RespValid_ValOut           = state_q == RESP;
    assign RespData_DatOut            = rdata_q;
    assign RespResponse_DatOut        = resp_q;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    assign RespTimeout_ValOut         = tmo_q;
`else
    assign RespTimeout_ValOut         = 1'b0;
`endif
    assign AxiWriteAddrValid_ValOut   = aw_q;
    assign AxiWriteAddrAddress_AdrOut = addr_q;
    assign AxiWriteAddrProt_DatOut    = 3'b000;
    assign AxiWriteDataValid_ValOut   = w_q;
    assign AxiWriteDataData_DatOut    = wdata_q;
    assign AxiWriteDataStrobe_DatOut  = strb_q;
    assign AxiWriteRespReady_RdyOut   = state_q == WR_RESP;
    assign AxiReadAddrValid_ValOut    = state_q == RD_ADDR;
    assign AxiReadAddrAddress_AdrOut  = addr_q;
    assign AxiReadAddrProt_DatOut     = 3'b000;
    assign AxiReadDataReady_RdyOut    = state_q == RD_DATA;
endmodule
